// File: rtl/ycbcr422_to_rgb.sv
// 4:2:2 YCbCr to RGB converter with a fixed 4-cycle pipeline (sync signals delayed to match).
// Define STUDIO_RANGE_EN for BT.601 studio-range coefficients; full-range (JPEG) otherwise.
module ycbcr422_to_rgb #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       y_in,
  input  logic [7:0]       c_in,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out
);

`ifdef STUDIO_RANGE_EN
  localparam logic signed [19:0] Y_OFF = 20'sd16;
  localparam logic signed [19:0] K_Y   = 20'sd298;
  localparam logic signed [19:0] K_R   = 20'sd409;
  localparam logic signed [19:0] K_G   = 20'sd208;
  localparam logic signed [19:0] K_B2  = 20'sd100;
  localparam logic signed [19:0] K_B   = 20'sd516;
`else
  localparam logic signed [19:0] Y_OFF = 20'sd0;
  localparam logic signed [19:0] K_Y   = 20'sd256;
  localparam logic signed [19:0] K_R   = 20'sd359;
  localparam logic signed [19:0] K_G   = 20'sd183;
  localparam logic signed [19:0] K_B2  = 20'sd88;
  localparam logic signed [19:0] K_B   = 20'sd454;
`endif

  localparam logic signed [19:0] C_MID = 20'sd128;

  function automatic logic [7:0] clamp8(input logic signed [19:0] sum);
    logic signed [19:0] t;
    t = (sum + 20'sd128) >>> 8;
    if (t < 20'sd0) begin
      clamp8 = 8'd0;
    end else if (t > 20'sd255) begin
      clamp8 = 8'd255;
    end else begin
      clamp8 = t[7:0];
    end
  endfunction

  function automatic logic [OUT_W-1:0] widen(input logic [7:0] v);
    logic [OUT_W-1:0] res;
    res = '0;
    for (int i = 0; i < OUT_W; i++) begin
      res[OUT_W-1-i] = v[7 - (i % 8)];
    end
    return res;
  endfunction

  logic [3:0]         de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]         y1_q, y1_d, c1_q, c1_d, cprev_q, cprev_d;
  logic               ph1_q, ph1_d;
  logic signed [19:0] yd2_q, yd2_d, cbd2_q, cbd2_d, crd2_q, crd2_d;
  logic signed [19:0] pk3_q, pk3_d, pr3_q, pr3_d, pgr3_q, pgr3_d;
  logic signed [19:0] pgb3_q, pgb3_d, pb3_q, pb3_d;
  logic [7:0]         r4_q, r4_d, g4_q, g4_d, b4_q, b4_d;
  logic [7:0]         cb_s, cr_s;

  // Next-state logic for all four pipeline stages.
  always_comb begin
    de_d = {de_q[2:0], de_in};
    hs_d = {hs_q[2:0], hsync_in};
    vs_d = {vs_q[2:0], vsync_in};

    y1_d    = y_in;
    c1_d    = c_in;
    cprev_d = c1_q;
    if (de_in) begin
      ph1_d = de_q[0] ? ~ph1_q : 1'b0;
    end else begin
      ph1_d = ph1_q;
    end

    // Even pixel borrows Cr from the pixel arriving behind it; neutral if the line has ended.
    if (!ph1_q) begin
      cb_s = c1_q;
      cr_s = de_in ? c_in : 8'd128;
    end else begin
      cb_s = cprev_q;
      cr_s = c1_q;
    end
    yd2_d  = $signed({12'd0, y1_q}) - Y_OFF;
    cbd2_d = $signed({12'd0, cb_s}) - C_MID;
    crd2_d = $signed({12'd0, cr_s}) - C_MID;

    pk3_d  = yd2_q * K_Y;
    pr3_d  = crd2_q * K_R;
    pgr3_d = crd2_q * K_G;
    pgb3_d = cbd2_q * K_B2;
    pb3_d  = cbd2_q * K_B;

    if (de_q[2]) begin
      r4_d = clamp8(pk3_q + pr3_q);
      g4_d = clamp8(pk3_q - pgr3_q - pgb3_q);
      b4_d = clamp8(pk3_q + pb3_q);
    end else begin
      r4_d = 8'd0;
      g4_d = 8'd0;
      b4_d = 8'd0;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 4'd0;
      hs_q    <= 4'd0;
      vs_q    <= 4'd0;
      y1_q    <= 8'd0;
      c1_q    <= 8'd0;
      cprev_q <= 8'd0;
      ph1_q   <= 1'b0;
      yd2_q   <= 20'sd0;
      cbd2_q  <= 20'sd0;
      crd2_q  <= 20'sd0;
      pk3_q   <= 20'sd0;
      pr3_q   <= 20'sd0;
      pgr3_q  <= 20'sd0;
      pgb3_q  <= 20'sd0;
      pb3_q   <= 20'sd0;
      r4_q    <= 8'd0;
      g4_q    <= 8'd0;
      b4_q    <= 8'd0;
    end else begin
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      y1_q    <= y1_d;
      c1_q    <= c1_d;
      cprev_q <= cprev_d;
      ph1_q   <= ph1_d;
      yd2_q   <= yd2_d;
      cbd2_q  <= cbd2_d;
      crd2_q  <= crd2_d;
      pk3_q   <= pk3_d;
      pr3_q   <= pr3_d;
      pgr3_q  <= pgr3_d;
      pgb3_q  <= pgb3_d;
      pb3_q   <= pb3_d;
      r4_q    <= r4_d;
      g4_q    <= g4_d;
      b4_q    <= b4_d;
    end
  end

  assign r_out     = widen(r4_q);
  assign g_out     = widen(g4_q);
  assign b_out     = widen(b4_q);
  assign de_out    = de_q[3];
  assign hsync_out = hs_q[3];
  assign vsync_out = vs_q[3];

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Scoreboard bench for ycbcr422_to_rgb: expectations queued per input cycle, checked 4 cycles later.
// Expected RGB values are hand-computed for both coefficient builds (STUDIO_RANGE_EN).
module tb_ycbcr422_to_rgb;
  localparam int OUT_W = 8;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       y_in, c_in;
  logic             de_in, hsync_in, vsync_in;
  logic [OUT_W-1:0] r_out, g_out, b_out;
  logic             de_out, hsync_out, vsync_out;

  always #5 clk = ~clk;

  ycbcr422_to_rgb #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .c_in(c_in), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  typedef struct packed {
    logic       de, hs, vs;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [OUT_W-1:0] expand(input logic [7:0] v);
    logic [15:0] rep;
    rep = {v, v};
    return rep[15 -: OUT_W];
  endfunction

  // One input cycle; queues the output expected LAT cycles later.
  task automatic drive(input logic r, input logic d, input logic h, input logic v,
                       input logic [7:0] yy, input logic [7:0] cc,
                       input logic [7:0] fr, input logic [7:0] fg, input logic [7:0] fb,
                       input logic [7:0] sr, input logic [7:0] sg, input logic [7:0] sb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; de_in = d; hsync_in = h; vsync_in = v; y_in = yy; c_in = cc;
    e.de = d; e.hs = h; e.vs = v;
`ifdef STUDIO_RANGE_EN
    e.r = d ? sr : 8'd0; e.g = d ? sg : 8'd0; e.b = d ? sb : 8'd0;
`else
    e.r = d ? fr : 8'd0; e.g = d ? fg : 8'd0; e.b = d ? fb : 8'd0;
`endif
    if (r) begin
      for (int i = 1; i < LAT; i++) exp_q[exp_q.size() - i] = '0;
      e = '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic pix(input logic [7:0] yy, input logic [7:0] cc,
                     input logic [7:0] fr, input logic [7:0] fg, input logic [7:0] fb,
                     input logic [7:0] sr, input logic [7:0] sg, input logic [7:0] sb);
    drive(1'b0, 1'b1, 1'b0, 1'b0, yy, cc, fr, fg, fb, sr, sg, sb);
  endtask

  task automatic idle(input logic h, input logic v, input logic [7:0] cc);
    drive(1'b0, 1'b0, h, v, 8'($urandom), cc, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  // Monitor: every cycle the oldest due expectation is compared with the outputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > LAT) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({de_out, hsync_out, vsync_out} !== {e.de, e.hs, e.vs}) begin
        n_fail++;
        $display("FAIL timing @%0t: de/hs/vs got %b%b%b expected %b%b%b", $time,
                 de_out, hsync_out, vsync_out, e.de, e.hs, e.vs);
      end
      n_checks++;
      if ({r_out, g_out, b_out} !== {expand(e.r), expand(e.g), expand(e.b)}) begin
        n_fail++;
        $display("FAIL rgb @%0t: got %0d,%0d,%0d expected %0d,%0d,%0d", $time,
                 r_out, g_out, b_out, expand(e.r), expand(e.g), expand(e.b));
      end
    end
  end

  initial begin
    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; y_in = 8'd0; c_in = 8'd0;
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);

    // Reset hold with random inputs, then 4 quiet cycles after release
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 8'($urandom));

    // Grey pair
    pix(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    pix(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    idle(1'b1, 1'b0, 8'd0);

    // White run, then black
    for (int i = 0; i < 8; i++)
      pix(8'd235, 8'd128, 8'd235, 8'd235, 8'd235, 8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 2; i++)
      pix(8'd16, 8'd128, 8'd16, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0);
    idle(1'b1, 1'b0, 8'd0);

    // Saturated red pair
    pix(8'd81, 8'd90,  8'd238, 8'd14, 8'd14, 8'd255, 8'd0, 8'd0);
    pix(8'd81, 8'd240, 8'd238, 8'd14, 8'd14, 8'd255, 8'd0, 8'd0);
    idle(1'b0, 1'b1, 8'd0);

    // Odd-length line, 1-cycle gap, new line restarts on Cb
    pix(8'd100, 8'd200, 8'd5,   8'd124, 8'd228, 8'd0,  8'd125, 8'd243);
    pix(8'd100, 8'd60,  8'd5,   8'd124, 8'd228, 8'd0,  8'd125, 8'd243);
    pix(8'd100, 8'd128, 8'd100, 8'd100, 8'd100, 8'd98, 8'd98,  8'd98);
    idle(1'b1, 1'b0, 8'd0);
    pix(8'd100, 8'd200, 8'd5,   8'd124, 8'd228, 8'd0,  8'd125, 8'd243);
    pix(8'd100, 8'd60,  8'd5,   8'd124, 8'd228, 8'd0,  8'd125, 8'd243);
    idle(1'b0, 1'b1, 8'd0);
    idle(1'b0, 1'b1, 8'd0);

    // Single-cycle data enable
    pix(8'd150, 8'd50, 8'd150, 8'd177, 8'd12, 8'd156, 8'd186, 8'd0);
    idle(1'b1, 1'b0, 8'd0);
    idle(1'b0, 1'b0, 8'd0);

    // Mid-line reset on an odd pixel; next pixel must restart as Cb
    pix(8'd81, 8'd90, 8'd238, 8'd14, 8'd14, 8'd255, 8'd0, 8'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd81, 8'd240, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    pix(8'd100, 8'd200, 8'd5, 8'd124, 8'd228, 8'd0, 8'd125, 8'd243);
    pix(8'd100, 8'd60,  8'd5, 8'd124, 8'd228, 8'd0, 8'd125, 8'd243);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b0, 8'd0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ycbcr422_to_rgb.md
# ycbcr422_to_rgb

Receive-side colour converter: accepts an 8-bit 4:2:2 YCbCr stream (Y on one bus, Cb/Cr interleaved on a second), reconstructs 4:4:4 chroma per pixel and produces 8-bit RGB with timing signals delayed to match. It is the inverse of the transmit-path RGB-to-YCbCr 4:2:2 converter. It sits between the video capture/decode front end and the RGB processing pipeline (binarisation, plate localisation).

## Interface
- `OUT_W`, default 8: output component width, legal range 8..10.
  - The result is computed at 8 bits.
  - It is then left-justified, with LSBs filled by replicating the MSBs.
- `clk` in 1: pixel clock. All logic is on the rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `y_in` in 8: luma.
- `c_in` in 8: chroma, interleaved Cb, Cr, Cb, Cr, … within each line.
- `de_in` in 1: data enable. Pixel valid when high.
- `hsync_in` in 1: horizontal sync, passed through.
- `vsync_in` in 1: vertical sync, passed through.
- `r_out` out OUT_W: red.
- `g_out` out OUT_W: green.
- `b_out` out OUT_W: blue.
- `de_out` out 1: delayed `de_in`.
- `hsync_out` out 1: delayed `hsync_in`.
- `vsync_out` out 1: delayed `vsync_in`.

## Operation
**Chroma phase**
- A phase bit is forced to 0 (Cb) on the first `de_in` high cycle after a low cycle.
- It toggles on every subsequent `de_in` high cycle.
- It is ignored while `de_in` is low.

**Pairing**
- Even pixel n (phase 0): Cb = own `c_in`; Cr = `c_in` of pixel n+1 (one-pixel lookahead).
- Odd pixel: Cr = own `c_in`; Cb = `c_in` of the preceding even pixel.

**Odd-length line**
- The final even pixel is followed by `de_in` low.
- Its Cr is 128, i.e. neutral.

**Arithmetic** (signed, ×256 fixed point)
- Offsets: Yd = Y − Yoff, Cbd = Cb − 128, Crd = Cr − 128.
- R = K·Yd + Kr·Crd
- G = K·Yd − Kg·Crd − Kb2·Cbd
- B = K·Yd + Kb·Cbd
- Each sum gets +128, then an arithmetic shift right by 8.
- The result is clamped to 0..255. Intermediate width is at least 20 bits signed, so no overflow is possible.
- The coefficient set is chosen by the Configuration macro.

**Blanking**
- While `de_out` is 0, `r_out`, `g_out` and `b_out` are 0.
- Syncs pass through unchanged.

**Reset**
- All outputs are 0.
- Delay lines and the lookahead buffer are cleared.
- The phase bit is 0.
- Reset asserted mid-line discards in-flight pixels. The first pixel after reset deassertion with `de_in`=1 is treated as phase 0.

## Timing
**Latency**
- Fixed 4 cycles from input to output for pixels and syncs (`de`, `hsync`, `vsync` all delayed by 4).
- Stage 1: input register. This is the lookahead tap.
- Stage 2: chroma select and offset subtraction.
- Stage 3: multiplies (5 products).
- Stage 4: sums, rounding, clamp, output register.

**Throughput and flow control**
- One pixel per clock.
- No back-pressure; there is no stall input.

**Lookahead at line end**
- The lookahead for the last even pixel samples stage 1 while `de` is low at stage 1. This selects the neutral Cr of 128.

**Reset release**
- Outputs remain 0 for 4 cycles after `rst` deasserts, until valid data propagates.

**Edge cases**
- `de_in` asserted for exactly 1 cycle: one pixel out, Cr=128.
- Back-to-back lines with a 1-cycle `de` gap: the phase restarts at 0 for each line.

## Configuration
Macro `STUDIO_RANGE_EN`:
- **Defined:** BT.601 studio range.
  - Yoff=16, K=298, Kr=409, Kg=208, Kb2=100, Kb=516.
  - Y=16 maps to black, Y=235 maps to white.
- **Undefined:** full range (JPEG).
  - Yoff=0, K=256, Kr=359, Kg=183, Kb2=88, Kb=454.
- Latency, interface and clamp behaviour are identical in both builds.

## Test plan
1. **Reset hold.** Drive `rst`=1 for 3 cycles with random inputs, then release. Required: every output 0 during reset and for 4 cycles after release.
2. **Studio white and black** (macro defined). Y=235, Cb=Cr=128 for 8 pixels with `de_in`=1, then Y=16. Required: RGB 255,255,255 appearing exactly 4 cycles after the input, then RGB 0,0,0.
3. **Studio red with clamping** (macro defined). Pair Y=81/81, Cb=90, Cr=240. Required: both pixels RGB 255,0,0; the negative G and B sums clamp to 0.
4. **Full-range grey** (macro undefined). Y=128, Cb=Cr=128. Required: RGB 128,128,128.
5. **Odd line length and phase restart.** A 3-pixel line (Y=100, Cb=200, Cr=60, then Y=100, Cb=128), then a 1-cycle gap, then a new line. Required:
   - Pixel 2 uses Cr=128.
   - The new line's first `c_in` is treated as Cb.
   - `de_out`, `hsync_out` and `vsync_out` equal the inputs delayed by exactly 4.
6. **Mid-line reset.** Pulse `rst` for 1 cycle during an active line, then resume with `de_in`=1. Required:
   - Outputs are 0 for 4 cycles.
   - The first post-reset pixel is treated as Cb phase, with RGB matching the reference model.
